// File: rtl/lvds_video_tx.sv
// lvds_video_tx: 7:1 LVDS video serialiser with timing generator and built-in test patterns
module lvds_video_tx #(
    parameter int COLOR_BITS = 6,
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 128,
    parameter int H_SYNC     = 20,
    parameter int H_BP       = 0,
    parameter int V_ACTIVE   = 310,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 17,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    localparam int NP        = (COLOR_BITS == 6) ? 3 : 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              pattern_sel,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    input  logic [3*COLOR_BITS-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_req,
    output logic [NP-1:0]           pairs,
    output logic                    pair_clk,
    output logic                    frame_start,
    output logic                    underflow,
    output logic [15:0]             frame_count
);
    localparam int C = COLOR_BITS;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_END  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_END  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam int BW  = H_ACTIVE / 8;
    localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [BCW-1:0] BW_LAST = BCW'(BW - 1);
    localparam logic [6:0] CLK_PAT = 7'b1100011;

    logic [2:0]            slot;
    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic [BCW-1:0]        bar_cnt;
    logic [2:0]            bar_idx;
    logic [1:0]            pat_q;
    logic                  req_pend;
    logic                  started;
    logic [NP-1:0][6:0]    word;
    logic [NP-1:0][6:0]    nw;
    logic                  first;
    logic                  load;
    logic                  de;
    logic                  hs;
    logic                  vs;
    logic                  rb;
    logic                  bb;
    logic [1:0]            pat;
    logic [3*C-1:0]        rgb;

    function automatic logic [6:0] pack_word(input int k, input logic [C-1:0] cr, cg, cb,
                                             input logic fde, fvs, fhs);
        return k == 0 ? {cg[0], cr[5:0]} :
               k == 1 ? {cb[1:0], cg[5:1]} :
               k == 2 ? {fde, fvs, fhs, cb[5:2]} :
                        {1'b0, cb[C-1:C-2], cg[C-1:C-2], cr[C-1:C-2]};
    endfunction

    // Timing flags, pattern selection and colour for the pixel (h,v) about to be loaded
    always_comb begin
        first = (h == '0) && (v == '0);
        load  = (slot == 3'd0);
        pat   = first ? pattern_sel : pat_q;
        de    = (h < H_ACT) && (v < V_ACT);
        hs    = (h >= HS_B && h < HS_E) ? HS_POL : ~HS_POL;
        vs    = (v >= VS_B && v < VS_E) ? VS_POL : ~VS_POL;
        rb    = (v == '0) || (v == V_END);
        bb    = (h == '0) || (h == H_END);
        rgb   = !de           ? '0 :
                pat == 2'd1   ? solid_rgb :
                pat == 2'd2   ? {{C{rb}}, {C{1'b0}}, {C{bb}}} :
                pat == 2'd3   ? {{C{bar_idx[2]}}, {C{bar_idx[1]}}, {C{bar_idx[0]}}} :
                (req_pend && pix_valid) ? pix_data : '0;
        for (int k = 0; k < NP; k++)
            nw[k] = pack_word(k, rgb[3*C-1:2*C], rgb[2*C-1:C], rgb[C-1:0], de, vs, hs);
    end

    // Serial outputs and the pixel request strobe, all forced low while in reset
    always_comb begin
        for (int k = 0; k < NP; k++)
            pairs[k] = ~reset & word[k][slot];
        pair_clk = ~reset & CLK_PAT[slot];
        pix_req  = ~reset & (slot == 3'd3) & de & (pat == 2'd0);
    end

    // Slot sequencer, raster counters, word load and frame bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= 3'd6;
            h           <= '0;
            v           <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pat_q       <= '0;
            req_pend    <= 1'b0;
            started     <= 1'b0;
            word        <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_count <= '0;
        end else begin
            slot        <= load ? 3'd6 : slot - 3'd1;
            frame_start <= load && first;
            if (slot == 3'd3)
                req_pend <= pix_req;
            if (load) begin
                word     <= nw;
                req_pend <= 1'b0;
                if (req_pend && !pix_valid)
                    underflow <= 1'b1;
                if (first) begin
                    pat_q   <= pattern_sel;
                    started <= 1'b1;
                    if (started)
                        frame_count <= frame_count + 16'd1;
                end
                h <= (h == H_LAST) ? '0 : h + 1'b1;
                if (h == H_LAST)
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                if (h == H_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= '0;
                end else if (bar_cnt == BW_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lvds_video_tx.sv
// tb_lvds_video_tx: directed bench for the 18-bit LVDS transmitter on a 14x7 raster
module tb_lvds_video_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pattern_sel = 2'd1;
    logic [17:0] solid_rgb = 18'h3FFFF;
    logic [17:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_req;
    logic [2:0]  pairs;
    logic        pair_clk;
    logic        frame_start;
    logic        underflow;
    logic [15:0] frame_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fs = 0;
    int req_cnt = 0;
    logic [1:0] pat_cur = '0;
    logic       exp_uf = 1'b0;
    logic [6:0] sh [3];
    logic [6:0] exp_w [3];

    always #5 clk = ~clk;

    lvds_video_tx #(
        .COLOR_BITS(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_req(pix_req), .pairs(pairs),
        .pair_clk(pair_clk), .frame_start(frame_start), .underflow(underflow),
        .frame_count(frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic restart();
        cyc = 0;
        fs = 0;
        req_cnt = 0;
        pat_cur = '0;
        exp_uf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sh[k] = '0;
            exp_w[k] = '0;
        end
    endtask

    task automatic reset_checks();
        check("rst_pairs", pairs, 0);
        check("rst_pair_clk", pair_clk, 0);
        check("rst_pix_req", pix_req, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underflow", underflow, 0);
        check("rst_frame_count", frame_count, 0);
    endtask

    // One clock cycle: sample at the falling edge, check, then act as the pixel source
    task automatic step();
        int slot, nq, h, v, f;
        logic [17:0] rgb;
        logic [2:0] hb;
        logic [1:0] pe;
        logic de, fe, drop;
        @(negedge clk);
        cyc++;
        slot = 6 - ((cyc - 1) % 7);
        nq = (cyc - 1) / 7;
        h = nq % 14;
        v = (nq / 14) % 7;
        f = nq / 98;
        de = (h < 8) && (v < 4);
        drop = (f == 3) && (h == 3) && (v == 1);
        check("pair_clk", pair_clk, (slot >= 5 || slot <= 1) ? 1 : 0);
        for (int k = 0; k < 3; k++)
            sh[k] = {sh[k][5:0], pairs[k]};
        fe = (slot == 6) && (nq >= 1) && ((nq - 1) % 98 == 0);
        if (fe)
            fs++;
        check("frame_start", frame_start, fe);
        check("frame_count", frame_count, fs > 0 ? fs - 1 : 0);
        check("underflow", underflow, exp_uf);
        pe = (h == 0 && v == 0) ? pattern_sel : pat_cur;
        check("pix_req", pix_req, (slot == 3) && de && (pe == 2'd0));
        if (cyc % 686 == 4 && cyc > 4) begin
            check("req_count", req_cnt, (cyc / 686 - 1 >= 2 && cyc / 686 - 1 <= 4) ? 32 : 0);
            req_cnt = 0;
        end
        if (pix_req)
            req_cnt++;
        if (pix_req && slot == 3) begin
            pix_valid = !drop;
            pix_data = {6'(h), 6'(v), 6'd0};
        end
        if (slot == 6)
            pix_valid = 1'b0;
        if (slot == 0) begin
            check("word0", sh[0], exp_w[0]);
            check("word1", sh[1], exp_w[1]);
            check("word2", sh[2], exp_w[2]);
            if (h == 0 && v == 0)
                pat_cur = pattern_sel;
            hb = 3'(h);
            if (!de)
                rgb = '0;
            else if (pat_cur == 2'd1)
                rgb = solid_rgb;
            else if (pat_cur == 2'd2)
                rgb = {(v == 0 || v == 3) ? 6'h3F : 6'h0, 6'h0, (h == 0 || h == 7) ? 6'h3F : 6'h0};
            else if (pat_cur == 2'd3)
                rgb = {hb[2] ? 6'h3F : 6'h0, hb[1] ? 6'h3F : 6'h0, hb[0] ? 6'h3F : 6'h0};
            else
                rgb = drop ? 18'h0 : {6'(h), 6'(v), 6'd0};
            exp_w[0] = {rgb[6], rgb[17:12]};
            exp_w[1] = {rgb[1:0], rgb[11:7]};
            exp_w[2] = {de, v == 5, h == 10 || h == 11, rgb[5:2]};
            if (pat_cur == 2'd0 && de && drop)
                exp_uf = 1'b1;
        end
    endtask

    initial begin
        restart();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 reset = 1'b0;
        while (cyc < 4842) begin
            step();
            if (cyc == 1000) pattern_sel = 2'd0;
            if (cyc == 3100) pattern_sel = 2'd3;
            if (cyc == 3700) pattern_sel = 2'd2;
        end
        reset = 1'b1;
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 reset = 1'b0;
        restart();
        repeat (20) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lvds_video_tx.md
LVDS_VIDEO_TX -- requirements
Module: lvds_video_tx

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- COLOR_BITS, 6, bits per colour channel; legal values 6 (18-bit, 3 data pairs) or 8 (24-bit, 4 data pairs).
- H_ACTIVE, 1024, active pixels per line; must be a multiple of 8.
- H_FP, 128, horizontal front porch, in pixels.
- H_SYNC, 20, horizontal sync width, in pixels.
- H_BP, 0, horizontal back porch, in pixels.
- V_ACTIVE, 310, active lines per frame.
- V_FP, 1, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 17, vertical back porch, in lines.
- HS_POL, 1, hsync level while asserted.
- VS_POL, 1, vsync level while asserted.
- NP = 3 when COLOR_BITS=6, else 4 (derived, not overridable).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, serial bit clock (7x pixel rate).
- reset, in, 1, synchronous, active-high.
- pattern_sel, in, 2, 0=external, 1=solid, 2=border, 3=colour bars.
- solid_rgb, in, 3*COLOR_BITS, colour used by pattern 1, ordered {R,G,B}.
- pix_data, in, 3*COLOR_BITS, external pixel, ordered {R,G,B}.
- pix_valid, in, 1, pix_data is valid.
- pix_req, out, 1, pixel request strobe.
- pairs, out, NP, serial data pairs.
- pair_clk, out, 1, LVDS clock pair.
- frame_start, out, 1, one-cycle pulse at the start of each frame.
- underflow, out, 1, sticky underflow flag.
- frame_count, out, 16, frames completed.

Function
REQ-003 slot counter counts 6 down to 0 then wraps to 6; one pixel period is 7 clk cycles; slot 6 is transmitted first.
REQ-004 pairs[k] = word[k][slot]; pair_clk = 7'b1100011[slot] (outside reset).
REQ-005 Word packing:
- word0 = {G0, R5..R0}.
- word1 = {B1, B0, G5..G1}.
- word2 = {DE, VS, HS, B5..B2}.
- word3, 24-bit only = {0, B7, B6, G7, G6, R7, R6}; with COLOR_BITS=8, R5..R0 etc. denote the low 6 bits of each channel.
REQ-006 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. They name the pixel loaded at the next slot==0 edge.
REQ-007 Counter advance at the slot==0 edge:
- h increments, wrapping to 0 at H_TOTAL-1.
- On the h wrap, v increments, wrapping to 0 at V_TOTAL-1.
REQ-008 Word registers load only at the slot==0 edge, from the current (h,v). Data loaded there is transmitted during the next 7 cycles (latency: 1 pixel period).
REQ-009 Timing flags:
- DE = (h < H_ACTIVE) && (v < V_ACTIVE).
- HS = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
- VS = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; VS is independent of h.
REQ-010 When DE=0, all colour bits loaded are 0, regardless of pattern_sel.
REQ-011 pix_req pulses high for exactly 1 cycle at slot==3 when the pixel (h,v) to be loaded at the following slot==0 has DE=1 and pattern_sel=0.
REQ-012 pix_data and pix_valid are sampled at the slot==0 edge following a pix_req.
REQ-013 If pix_valid=0 at that edge: colour is loaded as 0 (black), and underflow sets and remains set until reset.
REQ-014 Pattern 1 (solid) loads solid_rgb on every active pixel.
REQ-015 Pattern 2 (border):
- Rows v==0 and v==V_ACTIVE-1 are all-ones red (other channels 0).
- Columns h==0 and h==H_ACTIVE-1 are all-ones blue (other channels 0).
- Where a row and a column coincide, red and blue are both all-ones.
- All other active pixels are 0.
REQ-016 Pattern 3 (colour bars): 8 bars, each H_ACTIVE/8 pixels wide, with index b=0..7 counted by a bar counter (no divider).
- Colour = {R=b[2]?max:0, G=b[1]?max:0, B=b[0]?max:0}.
- The bar counter clears at h==0.
REQ-017 pattern_sel is sampled at the slot==0 edge where (h,v)=(0,0). A change takes effect only from the next frame; no mid-frame switch.
REQ-018 frame_start pulses for 1 cycle at the slot==0 edge loading (0,0).
REQ-019 frame_count increments, wrapping modulo 2^16, at that same edge, except for the first (0,0) load after reset.
REQ-020 If pix_valid is high with no preceding pix_req, it is ignored.

Reset
REQ-021 While reset=1:
- slot=6; h=0, v=0; bar counter=0.
- All words=0.
- pairs=0 and pair_clk=0 (forced).
- pix_req=0, frame_start=0, underflow=0, frame_count=0.
- Latched pattern_sel=0.
REQ-022 First cycle after release:
- slot=6; the all-zero word is transmitted.
- pair_clk follows the clock pattern immediately.
- Pixel (0,0) loads at the 7th cycle, with frame_start pulsing then.
REQ-023 Reset asserted mid-frame returns all state to the REQ-021 values at the next edge; no partial word completes.

Verification (params: H 8/2/2/2 -> H_TOTAL 14; V 4/1/1/1 -> V_TOTAL 7; COLOR_BITS=6)
REQ-024 Idle clock: release reset, run 70 cycles -> pair_clk = 1,1,0,0,0,1,1 repeating from cycle 1.
REQ-025 Timing: pattern_sel=1, solid_rgb=all ones, run 2 frames (686 cycles).
- DE=1 for h 0..7 with v 0..3.
- HS=1 for h 10..11.
- VS=1 on v=5.
- frame_start period = 686 cycles.
- frame_count=1 at the second frame_start.
REQ-026 External handshake: pattern_sel=0; source returns pix_data = {R=h,G=v,B=0}, valid on each pix_req.
- Exactly 32 pix_req per frame.
- Each serialised word matches REQ-005 one pixel period after the sample.
REQ-027 Underflow: drop pix_valid for pixel (3,1) -> that pixel is black; underflow=1 and remains 1 through subsequent frames until reset.
REQ-028 Bars/switch: select pattern 3 mid-frame -> the current frame is unchanged. Next frame h=0..7 yields RGB = 000, 001, 010, 011, 100, 101, 110, 111 (one bar per pixel).
REQ-029 Reset mid-line at slot=2, h=5 -> next cycle pairs=0, pair_clk=0, frame_count=0; the REQ-022 sequence restarts.
